// File: rtl/word_uart_tx_pkg.sv
// Shared definitions for the hex-word UART transmitter: FSM state type,
// ASCII constants, default baud divisor and the nibble-to-ASCII helper.
package word_uart_tx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] nibble);
    logic [7:0] c;
    if (nibble < 4'd10) begin
      c = ASCII_ZERO + {4'd0, nibble};
    end else begin
      c = ASCII_UPPER_A + {4'd0, nibble} - 8'd10;
    end
    return c;
  endfunction

endpackage

// File: rtl/word_uart_tx_byte_tx.sv
// uart_byte_tx: 8N1 serializer. A byte offered with start during the final
// stop-bit cycle (last=1) is chained without an idle gap.
module uart_byte_tx
  import word_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       last,
  output logic       tx
);

  localparam int            BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_r;
  uart_state_e   state_next_s;
  logic [BW-1:0] baud_r;
  logic [BW-1:0] baud_next_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic          tx_r;
  logic          tx_next_s;
  logic          bit_end_s;

  assign bit_end_s = (baud_r == BAUD_MAX);
  assign last      = (state_r == STOP) && bit_end_s;
  assign busy      = (state_r != IDLE);
  assign tx        = tx_r;

  // Next-state, counter and line-level decode; tx is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = bit_end_s ? {BW{1'b0}} : baud_r + BW'(1);
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    tx_next_s    = tx_r;
    case (state_r)
      IDLE: begin
        baud_next_s = {BW{1'b0}};
        if (start) begin
          state_next_s = START;
          shift_next_s = data;
          tx_next_s    = 1'b0;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_next_s = DATA;
          bit_next_s   = 3'd0;
          tx_next_s    = shift_r[0];
          shift_next_s = {1'b0, shift_r[7:1]};
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          bit_next_s = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            state_next_s = STOP;
            tx_next_s    = 1'b1;
          end else begin
            tx_next_s    = shift_r[0];
            shift_next_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (start) begin
            state_next_s = START;
            shift_next_s = data;
            tx_next_s    = 1'b0;
          end else begin
            state_next_s = IDLE;
            tx_next_s    = 1'b1;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
        baud_next_s  = {BW{1'b0}};
        bit_next_s   = 3'd0;
        tx_next_s    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and line register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      baud_r  <= baud_next_s;
      bit_r   <= bit_next_s;
      shift_r <= shift_next_s;
      tx_r    <= tx_next_s;
    end
  end

endmodule

// File: rtl/word_uart_tx.sv
// word_uart_tx: captures a 16-bit word and sends it as four uppercase ASCII hex
// characters, MSN first. Define WORD_UART_TX_CRLF_EN to append CR LF.
module word_uart_tx
  import word_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] word,
  output logic        ready,
  output logic        done,
  output logic        tx
);

`ifdef WORD_UART_TX_CRLF_EN
  localparam int CHAR_NUM = 6;
`else
  localparam int CHAR_NUM = 4;
`endif
  localparam int            CW        = $clog2(CHAR_NUM + 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_NUM);

  logic [15:0]   word_r;
  logic [15:0]   word_next_s;
  logic [CW-1:0] char_cnt_r;
  logic [CW-1:0] char_cnt_next_s;
  logic          ready_r;
  logic          ready_next_s;
  logic          done_r;
  logic          done_next_s;
  logic          accept_s;
  logic          chain_s;
  logic          byte_start_s;
  logic [7:0]    byte_data_s;
  logic [7:0]    next_char_s;
  logic          byte_busy_s;
  logic          byte_last_s;

  // The first character comes straight from the input word so its start bit leaves on the accept edge.
  assign accept_s     = valid && ready_r && !byte_busy_s;
  assign chain_s      = byte_last_s && (char_cnt_r < CHAR_LAST);
  assign byte_start_s = accept_s || chain_s;
  assign byte_data_s  = accept_s ? hex_char(word[15:12]) : next_char_s;
  assign ready        = ready_r;
  assign done         = done_r;

  // Character selected by the index of the next character still to be sent.
  always_comb begin
    next_char_s = 8'h00;
    case (char_cnt_r)
      CW'(0):  next_char_s = hex_char(word_r[15:12]);
      CW'(1):  next_char_s = hex_char(word_r[11:8]);
      CW'(2):  next_char_s = hex_char(word_r[7:4]);
      CW'(3):  next_char_s = hex_char(word_r[3:0]);
`ifdef WORD_UART_TX_CRLF_EN
      CW'(4):  next_char_s = ASCII_CR;
      CW'(5):  next_char_s = ASCII_LF;
`endif
      default: next_char_s = 8'h00;
    endcase
  end

  // Word capture, character sequencing and the ready/done handshake.
  always_comb begin
    word_next_s     = word_r;
    char_cnt_next_s = char_cnt_r;
    ready_next_s    = ready_r;
    done_next_s     = 1'b0;
    if (accept_s) begin
      word_next_s     = word;
      char_cnt_next_s = CW'(1);
      ready_next_s    = 1'b0;
    end else if (byte_last_s) begin
      if (char_cnt_r < CHAR_LAST) begin
        char_cnt_next_s = char_cnt_r + CW'(1);
      end else begin
        char_cnt_next_s = {CW{1'b0}};
        ready_next_s    = 1'b1;
        done_next_s     = 1'b1;
      end
    end else begin
      char_cnt_next_s = char_cnt_r;
    end
  end

  // Sequencer registers; ready and done are driven straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r     <= 16'd0;
      char_cnt_r <= {CW{1'b0}};
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      word_r     <= word_next_s;
      char_cnt_r <= char_cnt_next_s;
      ready_r    <= ready_next_s;
      done_r     <= done_next_s;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start_s),
    .data (byte_data_s),
    .busy (byte_busy_s),
    .last (byte_last_s),
    .tx   (tx)
  );

endmodule

// File: tb/tb_word_uart_tx.sv
// Scoreboard bench for word_uart_tx: expected bytes are queued at stimulus
// time, UART monitors decode tx and compare. Honours WORD_UART_TX_CRLF_EN.
module tb_word_uart_tx;

  localparam int P1 = 4;
  localparam int P2 = 2;
`ifdef WORD_UART_TX_CRLF_EN
  localparam int LAT1 = 241;
  localparam int LAT2 = 121;
`else
  localparam int LAT1 = 161;
  localparam int LAT2 = 81;
`endif

  logic        clk;
  logic        rst;
  logic        valid1, valid2;
  logic [15:0] word1, word2;
  logic        ready1, ready2;
  logic        done1, done2;
  logic        tx1, tx2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int n_checks;
  int n_fail;
  int done_cnt1;
  int done_cnt2;
  logic tx_prev1 = 1'b1;
  logic tx_prev2 = 1'b1;

  word_uart_tx #(.CLKS_PER_BIT(P1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid1), .word(word1),
    .ready(ready1), .done(done1), .tx(tx1)
  );

  word_uart_tx #(.CLKS_PER_BIT(P2)) dut2 (
    .clk(clk), .rst(rst), .valid(valid2), .word(word2),
    .ready(ready2), .done(done2), .tx(tx2)
  );

  always #5 clk = ~clk;

  function automatic logic txv(input int sel);
    return (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 1) ? ready1 : ready2;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input int sel, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    if (sel == 1) begin
      q1.push_back(c0); q1.push_back(c1); q1.push_back(c2); q1.push_back(c3);
`ifdef WORD_UART_TX_CRLF_EN
      q1.push_back(8'h0D); q1.push_back(8'h0A);
`endif
    end else begin
      q2.push_back(c0); q2.push_back(c1); q2.push_back(c2); q2.push_back(c3);
`ifdef WORD_UART_TX_CRLF_EN
      q2.push_back(8'h0D); q2.push_back(8'h0A);
`endif
    end
  endtask

  // Decode one frame whose first start-bit sample was just seen; every bit must be p samples wide.
  task automatic rx_frame(input int sel, input int p);
    logic [7:0] b;
    logic [7:0] e;
    logic bad;
    b = 8'h00;
    bad = 1'b0;
    for (int i = 1; i < p; i++) begin
      @(negedge clk);
      if (rst) return;
      if (txv(sel) !== 1'b0) bad = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        if (rst) return;
        if (i == 0) b[k] = txv(sel);
        else if (txv(sel) !== b[k]) bad = 1'b1;
      end
    end
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (rst) return;
      if (txv(sel) !== 1'b1) bad = 1'b1;
    end
    chk("bit_width", {31'd0, bad}, 32'd0);
    if ((sel == 1 && q1.size() == 0) || (sel == 2 && q2.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_byte dut%0d: got 0x%0h, expected no byte", sel, b);
    end else begin
      e = (sel == 1) ? q1.pop_front() : q2.pop_front();
      chk("rx_byte", {24'd0, b}, {24'd0, e});
    end
  endtask

  // Serial monitor for the CLKS_PER_BIT=4 instance.
  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx_prev1 === 1'b1 && tx1 === 1'b0) rx_frame(1, P1);
    tx_prev1 = tx1;
  end

  // Serial monitor for the CLKS_PER_BIT=2 instance.
  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx_prev2 === 1'b1 && tx2 === 1'b0) rx_frame(2, P2);
    tx_prev2 = tx2;
  end

  // Done-pulse monitor: counts pulses and requires ready alongside done.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      done_cnt1++;
      chk("done_with_ready1", {31'd0, ready1}, 32'd1);
    end
    if (done2 === 1'b1) begin
      done_cnt2++;
      chk("done_with_ready2", {31'd0, ready2}, 32'd1);
    end
  end

  task automatic send(input int sel, input logic [15:0] w);
    if (sel == 1) begin word1 = w; valid1 = 1'b1; end
    else begin word2 = w; valid2 = 1'b1; end
    @(posedge clk);
    #1;
    if (sel == 1) valid1 = 1'b0;
    else valid2 = 1'b0;
    chk("start_bit_next_cycle", {31'd0, txv(sel)}, 32'd0);
    chk("ready_drop", {31'd0, rdy(sel)}, 32'd0);
  endtask

  task automatic wait_done(input int sel, input int n0, input int exp, input bit scramble);
    int n;
    n = n0;
    if (scramble) word1 = 16'($urandom);
    while (dn(sel) !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble) word1 = 16'($urandom);
    end
    chk("done_latency", n, exp);
  endtask

  initial begin
    int d0;
    clk = 1'b0; rst = 1'b0;
    valid1 = 1'b0; valid2 = 1'b0; word1 = 16'd0; word2 = 16'd0;
    n_checks = 0; n_fail = 0; done_cnt1 = 0; done_cnt2 = 0;
    #1 rst = 1'b1;
    #11;
    chk("rst_tx1", {31'd0, tx1}, 32'd1);
    chk("rst_ready1", {31'd0, ready1}, 32'd1);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_tx2", {31'd0, tx2}, 32'd1);
    chk("rst_ready2", {31'd0, ready2}, 32'd1);
    chk("rst_done2", {31'd0, done2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    push_word(1, 8'h31, 8'h41, 8'h32, 8'h46);
    send(1, 16'h1A2F);
    wait_done(1, 1, LAT1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    push_word(1, 8'h30, 8'h30, 8'h30, 8'h30);
    send(1, 16'h0000);
    wait_done(1, 1, LAT1, 1'b0);
    push_word(1, 8'h46, 8'h46, 8'h46, 8'h46);
    send(1, 16'hFFFF);
    wait_done(1, 1, LAT1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    push_word(1, 8'h42, 8'h45, 8'h45, 8'h46);
    send(1, 16'hBEEF);
    repeat (19) @(posedge clk);
    #1;
    word1 = 16'h1234; valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    chk("busy_ignores_valid", {31'd0, ready1}, 32'd0);
    wait_done(1, 21, LAT1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done1}, 32'd0);

    push_word(1, 8'h41, 8'h42, 8'h43, 8'h44);
    send(1, 16'hABCD);
    repeat (49) @(posedge clk);
    #2;
    d0 = done_cnt1;
    rst = 1'b1;
    #1;
    chk("abort_tx_high", {31'd0, tx1}, 32'd1);
    chk("abort_ready", {31'd0, ready1}, 32'd1);
    chk("abort_no_done", {31'd0, done1}, 32'd0);
    @(negedge clk);
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_done_count", done_cnt1, d0);
    push_word(1, 8'h30, 8'h30, 8'h30, 8'h31);
    send(1, 16'h0001);
    wait_done(1, 1, LAT1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    push_word(1, 8'h35, 8'h41, 8'h35, 8'h41);
    send(1, 16'h5A5A);
    wait_done(1, 1, LAT1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    push_word(2, 8'h38, 8'h30, 8'h30, 8'h30);
    send(2, 16'h8000);
    wait_done(2, 1, LAT2, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    chk("done_pulses1", done_cnt1, 32'd6);
    chk("done_pulses2", done_cnt2, 32'd1);
    chk("idle_tx1", {31'd0, tx1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
